// File: rtl/mmu_job_arbiter_if.sv
// Requester-side and MMU-side signal bundle for the MMU job arbiter.
// master = requesters plus MMU control unit, slave = arbiter.
interface mmu_job_arbiter_if;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [1:0] in_valid;
    logic [7:0] in_data0;
    logic [7:0] in_data1;
    logic [1:0] in_ready;
    logic       mmu_load_en;
    logic [7:0] mmu_data;
    logic       mmu_done;
    logic [7:0] mmu_out;
    logic [1:0] out_valid;
    logic [7:0] out_data;
    logic [1:0] out_ready;
    logic       busy;
    logic       err;

    modport master (
        output req, in_valid, in_data0, in_data1, mmu_done, mmu_out, out_ready,
        input  gnt, in_ready, mmu_load_en, mmu_data, out_valid, out_data, busy, err
    );

    modport slave (
        input  req, in_valid, in_data0, in_data1, mmu_done, mmu_out, out_ready,
        output gnt, in_ready, mmu_load_en, mmu_data, out_valid, out_data, busy, err
    );
endinterface

// File: rtl/mmu_job_arbiter.sv
// Round-robin arbiter serialising whole 8-byte-load / 8-byte-result jobs onto one MMU.
// Optional WAIT timeout with 0xFF result fill: define MMU_ARB_TIMEOUT_EN.
module mmu_job_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    mmu_job_arbiter_if.slave   bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_CAPTURE, S_RETURN} state_t;

    state_t     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] in_ready_q, in_ready_d;
    logic       load_en_q, load_en_d;
    logic [7:0] mmu_data_q, mmu_data_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic       busy_q, busy_d;
    logic       rr_last_q, rr_last_d;
    logic [7:0] rbuf_q [8];
    logic [7:0] rbuf_d [8];
    logic       gidx_c;
    logic       pick_c;
    logic       xfer_c;
    logic       ret_c;
`ifdef MMU_ARB_TIMEOUT_EN
    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);
    logic [3:0] wcnt_q, wcnt_d;
    logic       err_q, err_d;
`endif

    // WAIT counter is 4 bits wide, so the limit must fit in it
    timeout_range_a: assert property (@(posedge clk) (TIMEOUT >= 1) && (TIMEOUT <= 15));

    assign gidx_c = gnt_q[1];
    assign pick_c = (bus.req == 2'b11) ? ~rr_last_q : bus.req[1];
    assign xfer_c = |(bus.in_valid & in_ready_q);
    assign ret_c  = |(out_valid_q & bus.out_ready);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        in_ready_d  = in_ready_q;
        load_en_d   = 1'b0;
        mmu_data_d  = mmu_data_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        rr_last_d   = rr_last_q;
        rbuf_d      = rbuf_q;
`ifdef MMU_ARB_TIMEOUT_EN
        wcnt_d      = wcnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    gnt_d      = pick_c ? 2'b10 : 2'b01;
                    in_ready_d = gnt_d;
                    cnt_d      = 3'd0;
                    state_d    = S_LOAD;
`ifdef MMU_ARB_TIMEOUT_EN
                    err_d      = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                if (xfer_c) begin
                    load_en_d  = 1'b1;
                    mmu_data_d = gidx_c ? bus.in_data1 : bus.in_data0;
                    cnt_d      = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        in_ready_d = 2'b00;
                        state_d    = S_WAIT;
`ifdef MMU_ARB_TIMEOUT_EN
                        wcnt_d     = 4'd0;
`endif
                    end
                end
            end
            S_WAIT: begin
                if (bus.mmu_done) begin
                    rbuf_d[0] = bus.mmu_out;
                    cnt_d     = 3'd1;
                    state_d   = S_CAPTURE;
                end
`ifdef MMU_ARB_TIMEOUT_EN
                else if (wcnt_q == WAIT_LAST) begin
                    // abort: requester still gets a full, recognisable result frame
                    for (int i = 0; i < 8; i++) rbuf_d[i] = 8'hFF;
                    err_d       = 1'b1;
                    cnt_d       = 3'd0;
                    out_valid_d = gnt_q;
                    out_data_d  = 8'hFF;
                    state_d     = S_RETURN;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
`endif
            end
            S_CAPTURE: begin
                rbuf_d[cnt_q] = bus.mmu_out;
                cnt_d         = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    out_valid_d = gnt_q;
                    out_data_d  = rbuf_q[0];
                    state_d     = S_RETURN;
                end
            end
            S_RETURN: begin
                if (ret_c) begin
                    cnt_d      = cnt_q + 3'd1;
                    out_data_d = rbuf_q[3'(cnt_q + 3'd1)];
                    if (cnt_q == 3'd7) begin
                        gnt_d       = 2'b00;
                        out_valid_d = 2'b00;
                        out_data_d  = 8'h00;
                        rr_last_d   = gidx_c;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Result buffer is never reset; it is only exposed after being refilled
    always_ff @(posedge clk) begin
        rbuf_q <= rbuf_d;
        if (rst) begin
            state_q     <= S_IDLE;
            gnt_q       <= 2'b00;
            in_ready_q  <= 2'b00;
            load_en_q   <= 1'b0;
            mmu_data_q  <= 8'h00;
            cnt_q       <= 3'd0;
            out_valid_q <= 2'b00;
            out_data_q  <= 8'h00;
            busy_q      <= 1'b0;
            rr_last_q   <= 1'b1;
`ifdef MMU_ARB_TIMEOUT_EN
            wcnt_q      <= 4'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            in_ready_q  <= in_ready_d;
            load_en_q   <= load_en_d;
            mmu_data_q  <= mmu_data_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            rr_last_q   <= rr_last_d;
`ifdef MMU_ARB_TIMEOUT_EN
            wcnt_q      <= wcnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.in_ready    = in_ready_q;
    assign bus.mmu_load_en = load_en_q;
    assign bus.mmu_data    = mmu_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.busy        = busy_q;
`ifdef MMU_ARB_TIMEOUT_EN
    assign bus.err         = err_q;
`else
    assign bus.err         = 1'b0;
`endif
endmodule

// File: tb/tb_mmu_job_arbiter.sv
// Directed-sequence bench for mmu_job_arbiter with random job data and a job-level reference model.
// Timeout scenario is built only when MMU_ARB_TIMEOUT_EN is defined.
module tb_mmu_job_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mmu_job_arbiter_if bus();
    mmu_job_arbiter #(.TIMEOUT(15)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    int bad = 0;
    int busy_cnt = 0;
    int ref_last = 1;
    logic [7:0] load_q [$];
    logic [7:0] res_q [$];
    logic [7:0] ld [8];
    logic [7:0] rs [8];

    // Collect what actually crossed each interface and flag cross-requester leaks
    always @(posedge clk) begin
        if (bus.mmu_load_en === 1'b1) load_q.push_back(bus.mmu_data);
        if ((bus.out_valid & bus.out_ready) != 2'b00) res_q.push_back(bus.out_data);
        if ((bus.out_valid & ~bus.gnt) != 2'b00) bad++;
        if ((bus.in_ready & ~bus.gnt) != 2'b00) bad++;
        if (bus.gnt == 2'b11) bad++;
        if (bus.busy === 1'b1) busy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] oh(input int r);
        return (r == 1) ? 2'b10 : 2'b01;
    endfunction

    // Reference arbitration: lone requester wins, otherwise whoever was not served last
    function automatic int pick(input logic [1:0] rq);
        if (rq == 2'b11) return 1 - ref_last;
        return rq[1] ? 1 : 0;
    endfunction

    task automatic reset_vals(input string tag);
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_load_en"}, 32'(bus.mmu_load_en), 32'd0);
        chk({tag, "_mmu_data"}, 32'(bus.mmu_data), 32'd0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
    endtask

    task automatic start(input logic [1:0] rq, output int r);
        r = pick(rq);
        bus.req = rq;
        tick();
        chk("grant", 32'(bus.gnt), 32'(oh(r)));
        chk("grant_in_ready", 32'(bus.in_ready), 32'(oh(r)));
        chk("grant_busy", 32'(bus.busy), 32'd1);
        chk("grant_err_clear", 32'(bus.err), 32'd0);
    endtask

    task automatic job(input int r, input int dly, input bit stall_in, input bit stall_out,
                       input int drop_at, input bit tmo, input bit rst_cap);
        int i;
        int k;
        int n;
        bit v;
        logic rdy;
        load_q.delete();
        res_q.delete();
        for (int j = 0; j < 8; j++) begin
            ld[j] = 8'($urandom);
            rs[j] = tmo ? 8'hFF : 8'($urandom);
        end
        i = 0;
        n = 0;
        while (i < 8 && n < 200) begin
            if (drop_at != 0 && i == drop_at) begin
                bus.req[r] = 1'b0;
                bus.in_valid = 2'b00;
                repeat (6) tick();
                chk("drop_gnt_held", 32'(bus.gnt), 32'(oh(r)));
                chk("drop_still_load", 32'(bus.in_ready), 32'(oh(r)));
                chk("drop_bytes", 32'(load_q.size()), 32'(drop_at));
                drop_at = 0;
            end
            rdy = bus.in_ready[r];
            v = stall_in ? n[0] : 1'b1;
            bus.in_valid[r] = v;
            bus.in_valid[1-r] = 1'b1;
            if (r == 0) begin
                bus.in_data0 = ld[i];
                bus.in_data1 = 8'hEE;
            end else begin
                bus.in_data1 = ld[i];
                bus.in_data0 = 8'hEE;
            end
            bus.mmu_done = 1'($urandom);
            bus.mmu_out = 8'($urandom);
            tick();
            n++;
            if (v && rdy === 1'b1) i++;
        end
        bus.in_valid = 2'b00;
        bus.mmu_done = 1'b0;
        chk("load_budget", 32'(i), 32'd8);
        chk("wait_in_ready", 32'(bus.in_ready), 32'd0);
        chk("wait_busy", 32'(bus.busy), 32'd1);
        if (tmo) begin
            for (int c = 0; c < 15; c++) begin
                chk("timeout_wait", 32'(bus.out_valid), 32'd0);
                bus.mmu_out = 8'($urandom);
                tick();
            end
        end else begin
            for (int c = 0; c < dly; c++) begin
                chk("wait_no_out", 32'(bus.out_valid), 32'd0);
                bus.mmu_out = 8'($urandom);
                tick();
            end
            for (int j = 0; j < 8; j++) begin
                if (rst_cap && j == 4) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    reset_vals("rst_capture");
                    ref_last = 1;
                    bus.mmu_done = 1'b0;
                    return;
                end
                bus.mmu_done = (j == 0);
                bus.mmu_out = rs[j];
                tick();
            end
            bus.mmu_done = 1'b0;
        end
        chk("out_valid_rise", 32'(bus.out_valid), 32'(oh(r)));
        chk("err_in_return", 32'(bus.err), 32'(tmo));
        k = 0;
        n = 0;
        while (k < 8 && n < 100) begin
            rdy = stall_out ? !(n >= 3 && n < 8) : 1'b1;
            bus.out_ready[r] = rdy;
            bus.out_ready[1-r] = 1'($urandom);
            chk("ret_data", 32'(bus.out_data), 32'(rs[k]));
            chk("ret_valid", 32'(bus.out_valid), 32'(oh(r)));
            tick();
            n++;
            if (rdy) k++;
        end
        bus.out_ready = 2'b00;
        chk("ret_budget", 32'(k), 32'd8);
        chk("end_gnt", 32'(bus.gnt), 32'd0);
        chk("end_busy", 32'(bus.busy), 32'd0);
        chk("end_out_valid", 32'(bus.out_valid), 32'd0);
        chk("end_err", 32'(bus.err), 32'(tmo));
        chk("load_count", 32'(load_q.size()), 32'd8);
        chk("res_count", 32'(res_q.size()), 32'd8);
        for (int j = 0; j < 8; j++) begin
            chk("load_byte", (j < load_q.size()) ? 32'(load_q[j]) : 32'hFFFF_FFFF, 32'(ld[j]));
            chk("res_byte", (j < res_q.size()) ? 32'(res_q[j]) : 32'hFFFF_FFFF, 32'(rs[j]));
        end
        ref_last = r;
    endtask

    initial begin
        int r;
        rst = 1'b1;
        bus.req = 2'b00;
        bus.in_valid = 2'b00;
        bus.in_data0 = 8'h00;
        bus.in_data1 = 8'h00;
        bus.mmu_done = 1'b0;
        bus.mmu_out = 8'h00;
        bus.out_ready = 2'b00;
        repeat (3) tick();
        rst = 1'b0;
        reset_vals("reset");

        // Contention from reset: requester 0 first, then 1, then 0 again
        start(2'b11, r);
        chk("contend_first_r0", 32'(r), 32'd0);
        job(r, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        start(2'b11, r);
        chk("contend_second_r1", 32'(r), 32'd1);
        job(r, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        start(2'b11, r);
        chk("contend_third_r0", 32'(r), 32'd0);
        bus.req = 2'b01;
        job(r, 1, 1'b0, 1'b0, 3, 1'b0, 1'b0);
        bus.req = 2'b00;
        tick();

        // Single unstalled job: busy spans LOAD 8 + WAIT (1+3) + CAPTURE 7 + RETURN 8
        busy_cnt = 0;
        start(2'b01, r);
        bus.req = 2'b00;
        job(r, 3, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("busy_cycles", 32'(busy_cnt), 32'(8 + 1 + 3 + 7 + 8));

        start(2'b10, r);
        bus.req = 2'b00;
        job(r, 5, 1'b1, 1'b1, 0, 1'b0, 1'b0);

        // Reset during CAPTURE, then a fresh job with new data
        start(2'b10, r);
        bus.req = 2'b00;
        job(r, 1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        tick();
        reset_vals("post_rst_idle");
        start(2'b11, r);
        chk("post_rst_ptr_r0", 32'(r), 32'd0);
        bus.req = 2'b00;
        job(r, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0);

`ifdef MMU_ARB_TIMEOUT_EN
        start(2'b10, r);
        bus.req = 2'b00;
        job(r, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        tick();
        chk("err_sticky_idle", 32'(bus.err), 32'd1);
        start(2'b01, r);
        bus.req = 2'b00;
        job(r, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0);
`endif

        chk("protocol_leaks", 32'(bad), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
